// File: rtl/jt12_snd_decim.sv
// jt12_snd_decim
// Decimating audio sink for the Megadrive/Genesis mixer path.
// Accumulates DIV accepted stereo input samples per channel (box-car
// accumulate-and-dump), scales the sum by an arithmetic right shift of
// SHIFT, saturates it to 16 bits and hands the pair to a consumer through
// a 2-entry FIFO with a valid/ready handshake.
//
// Parameters:
//   DIV   input samples per output sample (2..65536)
//   SHIFT arithmetic right shift applied to the sum (gain = DIV/2^SHIFT)
//   ACCW  accumulator width, at least 16+ceil(log2(DIV))
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cen_in     input sample strobe
//   snd_left   signed left input, sampled when cen_in=1
//   snd_right  signed right input, sampled when cen_in=1
//   out_left   signed decimated left sample at FIFO head
//   out_right  signed decimated right sample at FIFO head
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head when out_valid=1
//   clip       sticky: an output sample saturated
//   ovf        sticky: a dump was dropped because the FIFO was full
//   flag_clr   synchronous clear of clip and ovf (a set on the same edge wins)
module jt12_snd_decim #(
  parameter int DIV   = 1024,
  parameter int SHIFT = 10,
  parameter int ACCW  = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen_in,
  input  logic signed [15:0] snd_left,
  input  logic signed [15:0] snd_right,
  output logic signed [15:0] out_left,
  output logic signed [15:0] out_right,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               clip,
  output logic               ovf,
  input  logic               flag_clr
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

  // ------------------------------------------------------------------
  // Sample counter: advances only on accepted samples, so cen_in gaps
  // simply stretch the accumulation window.
  // ------------------------------------------------------------------
  logic [CW-1:0] cnt_reg;
  logic          block_end;

  assign block_end = cen_in && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cen_in) begin
      cnt_reg <= block_end ? '0 : cnt_reg + 1'b1;
    end
  end

  // Dump pending: set by the last sample of a block, consumed on the next
  // edge by the FIFO write stage. DIV>=2 guarantees no overlap.
  logic dump_pend_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_pend_reg <= 1'b0;
    end else if (block_end) begin
      dump_pend_reg <= 1'b1;
    end else if (dump_pend_reg) begin
      dump_pend_reg <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Per-channel accumulate, dump, scale and saturate.
  // Channel 0 = left, channel 1 = right.
  // ------------------------------------------------------------------
  logic signed [15:0] snd_in  [2];
  logic signed [15:0] sat_val [2];
  logic [1:0]         sat_hit;

  assign snd_in[0] = snd_left;
  assign snd_in[1] = snd_right;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [ACCW-1:0] acc_reg;
      logic signed [ACCW-1:0] dump_reg;
      logic signed [ACCW-1:0] snd_ext;
      logic signed [ACCW-1:0] shifted;
      logic signed [15:0]     sat_loc;
      logic                   hit_loc;

      assign snd_ext = {{(ACCW-16){snd_in[gi][15]}}, snd_in[gi]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg  <= '0;
          dump_reg <= '0;
        end else if (cen_in) begin
          if (block_end) begin
            // The last sample joins the dump directly so the block is
            // exactly DIV samples and the accumulator restarts clean.
            dump_reg <= acc_reg + snd_ext;
            acc_reg  <= '0;
          end else begin
            acc_reg  <= acc_reg + snd_ext;
          end
        end
      end

      assign shifted = dump_reg >>> SHIFT;

      always_comb begin
        hit_loc = 1'b0;
        sat_loc = shifted[15:0];
        if (shifted > SAT_MAX) begin
          hit_loc = 1'b1;
          sat_loc = 16'sh7fff;
        end else if (shifted < SAT_MIN) begin
          hit_loc = 1'b1;
          sat_loc = -16'sh8000;
        end
      end

      assign sat_val[gi] = sat_loc;
      assign sat_hit[gi] = hit_loc;
    end
  endgenerate

  // ------------------------------------------------------------------
  // 2-entry FIFO. A write into a full FIFO still succeeds when the head
  // is popped on the same edge; otherwise the pair is dropped.
  // ------------------------------------------------------------------
  logic signed [15:0] mem_left  [2];
  logic signed [15:0] mem_right [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;
  logic               pop;
  logic               push;

  assign pop  = out_valid && out_ready;
  assign push = dump_pend_reg && ((count_reg != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_left[i]  <= '0;
        mem_right[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_left[wr_ptr_reg]  <= sat_val[0];
        mem_right[wr_ptr_reg] <= sat_val[1];
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 2'd1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 2'd1;
      end
    end
  end

  // Head is read straight from the storage registers; when empty it shows
  // whatever the read pointer last addressed (zero after reset).
  assign out_left  = mem_left[rd_ptr_reg];
  assign out_right = mem_right[rd_ptr_reg];
  assign out_valid = (count_reg != 2'd0);

  // ------------------------------------------------------------------
  // Sticky flags. Saturation is flagged whether or not the pair fits.
  // ------------------------------------------------------------------
  logic clip_reg;
  logic ovf_reg;
  logic clip_set;
  logic ovf_set;

  assign clip_set = dump_pend_reg && (|sat_hit);
  assign ovf_set  = dump_pend_reg && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      if (clip_set)      clip_reg <= 1'b1;
      else if (flag_clr) clip_reg <= 1'b0;
      if (ovf_set)       ovf_reg  <= 1'b1;
      else if (flag_clr) ovf_reg  <= 1'b0;
    end
  end

  assign clip = clip_reg;
  assign ovf  = ovf_reg;

endmodule
